// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating starvation counter: counts cycles the external port lost arbitration.
module mem_arb_wait_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignment so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With MAX_WAIT=0 the counter never leaves zero, so ext wins every tie.
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port synchronous memory, with CPU
// priority, a starvation bound for the external port and a 1-cycle read return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  logic   at_max;
  logic   ext_wait;
  owner_e ret_owner_q, ret_owner_d;

  // Ext wins when alone or once it has lost MAX_WAIT ties in a row.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!reset) begin
      if (ext_req && (!cpu_req || at_max)) begin
        ext_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign ext_wait  = ext_req & ~ext_gnt;

  mem_arb_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (ext_wait),
    .clr   (~ext_wait),
    .at_max(at_max)
  );

  always_comb begin
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_gnt & cpu_we;
    end
  end

  // Return-owner FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_owner_q <= OWN_NONE;
    end else begin
      ret_owner_q <= ret_owner_d;
    end
  end

  // Next state depends only on this cycle's grant; writes return nothing.
  always_comb begin
    ret_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      ret_owner_d = OWN_CPU;
    end else if (ext_gnt && !ext_we) begin
      ret_owner_d = OWN_EXT;
    end
  end

  always_comb begin
    cpu_rvalid = (ret_owner_q == OWN_CPU);
    ext_rvalid = (ret_owner_q == OWN_EXT);
  end

  assign cpu_rdata = mem_q;
  assign ext_rdata = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory;
// a second instance is built with MAX_WAIT=0.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_we;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_q;

  logic        z_cpu_req, z_ext_req;
  logic        z_cpu_gnt, z_cpu_stall, z_cpu_rvalid, z_ext_gnt, z_ext_rvalid, z_mem_we;
  logic [15:0] z_cpu_rdata, z_ext_rdata, z_mem_addr, z_mem_wdata;
  logic [15:0] z_mem_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
  );

  mem_port_arbiter #(.MAX_WAIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0001), .cpu_wdata(16'h0000),
    .cpu_gnt(z_cpu_gnt), .cpu_stall(z_cpu_stall), .cpu_rvalid(z_cpu_rvalid), .cpu_rdata(z_cpu_rdata),
    .ext_req(z_ext_req), .ext_we(1'b0), .ext_addr(16'h0002), .ext_wdata(16'h0000),
    .ext_gnt(z_ext_gnt), .ext_rvalid(z_ext_rvalid), .ext_rdata(z_ext_rdata),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we), .mem_q(z_mem_q)
  );

  // Memory model: unwritten locations read as 16'h5A00 ^ addr; read-before-write.
  logic [15:0]  mem [0:255];
  logic [255:0] written = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_q <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (16'h5A00 ^ mem_addr);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, mem_we, cpu_rvalid, ext_rvalid} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000", {cpu_gnt, ext_gnt, mem_we, cpu_rvalid, ext_rvalid});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_addr} !== {3'b100, 16'h0010}) begin
      errors++;
      $display("FAIL release_grant got %b/%h exp 100/0010", {cpu_gnt, ext_gnt, cpu_stall}, mem_addr);
    end
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {2'b10, 16'h5A10}) begin
      errors++;
      $display("FAIL release_rdata got %b/%h exp 10/5a10", {cpu_rvalid, ext_rvalid}, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_cpu_only;
    logic [15:0] exp_data [3] = '{16'h5A00, 16'h5A01, 16'h5A02};
    cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_req  = (i < 3);
      cpu_addr = 16'(i);
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin
          errors++;
          $display("FAIL cpu_only_gnt[%0d] got %b exp 100", i, {cpu_gnt, ext_gnt, cpu_stall});
        end
      end
      if (i > 0) begin
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, exp_data[i-1]}) begin
          errors++;
          $display("FAIL cpu_only_rdata[%0d] got %b/%h exp 1/%h", i, cpu_rvalid, cpu_rdata, exp_data[i-1]);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_only_idle got %b exp 0", cpu_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_starvation;
    logic exp_ext, exp_crv;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_ext = (c == 5) || (c == 10);
      exp_crv = (c != 1) && (c != 6);
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== (exp_ext ? 3'b011 : 3'b100)) begin
        errors++;
        $display("FAIL starve_gnt[%0d] got %b exp %b", c, {cpu_gnt, ext_gnt, cpu_stall},
                 exp_ext ? 3'b011 : 3'b100);
      end
      checks++;
      if ({cpu_rvalid, ext_rvalid} !== {exp_crv, c == 6}) begin
        errors++;
        $display("FAIL starve_rvalid[%0d] got %b exp %b", c, {cpu_rvalid, ext_rvalid}, {exp_crv, c == 6});
      end
      if (c == 5) begin
        checks++;
        if (mem_addr !== 16'h0100) begin
          errors++;
          $display("FAIL starve_addr got %h exp 0100", mem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (ext_rdata !== 16'h5B00) begin
          errors++;
          $display("FAIL starve_rdata got %h exp 5b00", ext_rdata);
        end
      end
      next_cycle();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, ext_rdata} !== {2'b01, 16'h5B00}) begin
      errors++;
      $display("FAIL starve_tail got %b/%h exp 01/5b00", {cpu_rvalid, ext_rvalid}, ext_rdata);
    end
    next_cycle();
  endtask

  task automatic test_ext_write_cpu_read;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0020; ext_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({ext_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 16'h0020, 16'hBEEF}) begin
      errors++;
      $display("FAIL ext_write got %b/%h/%h exp 101/0020/beef", {ext_gnt, cpu_gnt, mem_we}, mem_addr, mem_wdata);
    end
    next_cycle();
    ext_req = 1'b0; ext_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, mem_we, ext_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL raw_read_gnt got %b exp 100", {cpu_gnt, mem_we, ext_rvalid});
    end
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 16'h0021; cpu_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {2'b10, 16'hBEEF}) begin
      errors++;
      $display("FAIL raw_rdata got %b/%h exp 10/beef", {cpu_rvalid, ext_rvalid}, cpu_rdata);
    end
    checks++;
    if ({cpu_gnt, mem_we, mem_wdata} !== {2'b11, 16'h1234}) begin
      errors++;
      $display("FAIL cpu_write got %b/%h exp 11/1234", {cpu_gnt, mem_we}, mem_wdata);
    end
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL write_no_rvalid got %b exp 00", {cpu_rvalid, ext_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0100;
    repeat (3) next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, mem_we, cpu_rvalid} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_gnt got %b exp 0001", {cpu_gnt, ext_gnt, mem_we, cpu_rvalid});
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt, ext_gnt} !== ((k == 5) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL mid_reset_wait[%0d] got %b exp %b", k, {cpu_gnt, ext_gnt}, (k == 5) ? 2'b01 : 2'b10);
      end
      if (k == 1) begin
        checks++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
          errors++;
          $display("FAIL mid_reset_rvalid got %b exp 00", {cpu_rvalid, ext_rvalid});
        end
      end
      next_cycle();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_max_wait0;
    z_cpu_req = 1'b1; z_ext_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) z_ext_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({z_cpu_gnt, z_ext_gnt, z_cpu_stall} !== ((k == 3) ? 3'b100 : 3'b011)) begin
        errors++;
        $display("FAIL max_wait0[%0d] got %b exp %b", k, {z_cpu_gnt, z_ext_gnt, z_cpu_stall},
                 (k == 3) ? 3'b100 : 3'b011);
      end
      next_cycle();
    end
    z_cpu_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    z_cpu_req = 1'b0; z_ext_req = 1'b0; z_mem_q = '0;
    test_reset();
    test_cpu_only();
    test_starvation();
    test_ext_write_cpu_read();
    test_reset_mid_read();
    test_max_wait0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single-port synchronous Memory between two requesters:
  - the CPU path (fetch/load/store addresses driven by the FSM and PC mux);
  - an external requester (program loader, debug or display read-back).
- Sits between the datapath and the Memory instance.
- Grants one access per cycle, CPU priority by default, with a starvation bound for the external port.
- Steers read data back to the owner with a one-cycle return pipeline and gives the FSM a stall signal.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MAX_WAIT, 4, consecutive cycles ext_req may lose to cpu_req before ext is forced to win (0 = ext always wins ties)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (level, held until granted)
- cpu_we  in  1  CPU write enable (1 = store, 0 = read)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; FSM holds pc_en/regwrite
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted CPU read)
- cpu_rdata  out  DATA_W  read data to the CPU
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  external request; same semantics as the CPU signals
- ext_gnt, ext_rvalid  out  1  external grant and read-valid
- ext_rdata  out  DATA_W  read data to the external requester
- mem_addr  out  ADDR_W  to Memory addr_a
- mem_wdata  out  DATA_W  to Memory data_a
- mem_we  out  1  to Memory we_a
- mem_q  in  DATA_W  from Memory q_a (valid the cycle after the address)

Behaviour:
- Reset (synchronous, while reset=1 at a clock edge):
  - wait_cnt=0, ret_owner=OWN_NONE;
  - cpu_rvalid=ext_rvalid=0;
  - gnt outputs are 0 while reset is high;
  - mem_we=0.
- Grant (combinational from the requests and registered wait_cnt):
  - only cpu_req: cpu_gnt=1.
  - only ext_req: ext_gnt=1.
  - both, wait_cnt<MAX_WAIT: cpu_gnt=1.
  - both, wait_cnt==MAX_WAIT: ext_gnt=1.
  - Never both grants in one cycle.
- wait_cnt update each edge:
  - ext_req & ~ext_gnt: increment, saturating at MAX_WAIT;
  - otherwise (ext granted or ext_req low): 0.
- Memory steering:
  - granted requester's addr/wdata/we drive mem_*;
  - mem_we = granted & owner's we;
  - no grant: mem_we=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- Return pipeline:
  - ret_owner register <= OWN_CPU / OWN_EXT for a granted read, else OWN_NONE;
  - next cycle: owner's rvalid=1;
  - cpu_rdata=ext_rdata=mem_q (pass-through, qualified by rvalid).
  - Read latency is exactly 1 cycle after grant. Writes produce no rvalid.
- Back-to-back:
  - a new grant is allowed every cycle, including the cycle rvalid is high for the previous read.
  - No forwarding: read-after-write ordering is whatever the Memory provides.
- Requests are level-sensitive:
  - a requester whose req is high and gnt low must hold req/addr/we/wdata stable;
  - a changed address while stalled is simply used when granted;
  - the arbiter keeps no request queue.
- Reset mid-operation: a read granted in the cycle reset is asserted produces no rvalid (ret_owner cleared).
- FSM view (ret_owner as state):
  - OWN_NONE / OWN_CPU / OWN_EXT;
  - transitions set solely by the current grant and we as above.

Decomposition:
- Package mem_arb_pkg:
  - owner enum OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_EXT=2'd2;
  - ADDR_W/DATA_W defaults;
  - default MAX_WAIT.
- One natural sub-module, mem_arb_wait_ctr:
  - saturating starvation counter;
  - inputs clk, reset, inc, clr;
  - output at_max.
- Grant/steer logic and return register stay in the top module.

Test Plan:
- Reset: hold reset=1 with cpu_req=1 read @0x0010 -> gnt=0, mem_we=0, no rvalid; release -> cpu_gnt=1 that cycle, cpu_rvalid=1 next cycle, cpu_rdata=mem[0x0010].
- CPU only: reads 0x0000,0x0001,0x0002 on consecutive cycles -> cpu_gnt=1 each cycle, cpu_rvalid high for 3 cycles starting 1 cycle later, data mem[0..2] in order, cpu_stall=0 throughout.
- Starvation bound (MAX_WAIT=4): cpu_req and ext_req (read @0x0100) both held -> CPU granted 4 cycles (cpu_stall=0), ext_gnt in cycle 5 with cpu_stall=1, ext_rvalid next cycle with mem[0x0100]; wait_cnt back to 0 and CPU granted again in cycle 6.
- Ext write then CPU read: ext write 0xBEEF @0x0020 alone (mem_we=1, no rvalid), then CPU read @0x0020 -> cpu_rdata=0xBEEF one cycle after grant, ext_rvalid stays 0.
- Reset mid-read: CPU read granted in the same cycle reset is asserted -> cpu_rvalid=0 next cycle; wait_cnt=0 after reset even if it was at 3.
- MAX_WAIT=0 build: simultaneous requests -> ext_gnt=1 every cycle and cpu_stall=1 while ext_req is held.
